// File: rtl/stream_pkg.sv
// Shared stream constants and the transmitter state encoding, common to the
// source, skid buffer and sink blocks of the byte-stream link.
package stream_pkg;

  localparam int STREAM_DATA_W = 8;
  localparam int STREAM_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/stream_pkt_tx.sv
// Packet source: one command in, cmd_len+1 incrementing bytes out, first beat 1 cycle after accept;
// holds beats under m_ready back-pressure. STREAM_TX_GAP_EN adds GAP_CYCLES idle cycles after each packet.
module stream_pkt_tx
  import stream_pkg::*;
#(
  parameter int DATA_W     = STREAM_DATA_W,
  parameter int LEN_W      = STREAM_LEN_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              pkt_done
);

  tx_state_t         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              pkt_done_q, pkt_done_d;

`ifdef STREAM_TX_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    pkt_done_d = 1'b0;
`ifdef STREAM_TX_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d     = cmd_len;
          cnt_d     = '0;
          m_data_d  = cmd_seed;
          m_valid_d = 1'b1;
          m_last_d  = (cmd_len == '0);
          state_d   = SEND;
        end
      end
      SEND: begin
        // m_valid is always high here, so m_ready alone marks the handshake
        if (m_ready) begin
          if (m_last_q) begin
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            pkt_done_d = 1'b1;
`ifdef STREAM_TX_GAP_EN
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d    = LEN_W'(cnt_q + 1'b1);
            m_data_d = m_data_q + 1'b1;
            m_last_d = (LEN_W'(cnt_q + 1'b1) == len_q);
          end
        end
      end
      GAP: begin
`ifdef STREAM_TX_GAP_EN
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      pkt_done_q <= 1'b0;
`ifdef STREAM_TX_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      pkt_done_q <= pkt_done_d;
`ifdef STREAM_TX_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign pkt_done  = pkt_done_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stream_pkt_tx.sv
// Directed bench for stream_pkt_tx; also covers the inter-packet gap when STREAM_TX_GAP_EN is defined.
module tb_stream_pkt_tx;

  localparam int TB_GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [7:0] cmd_seed;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic       pkt_done;

  int n_vec = 0;
  int n_err = 0;

  stream_pkt_tx #(.DATA_W(8), .LEN_W(8), .GAP_CYCLES(TB_GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_seed  (cmd_seed),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".m_valid"},   m_valid,   1'b0);
    check({tag, ".m_last"},    m_last,    1'b0);
    check({tag, ".busy"},      busy,      1'b0);
    check({tag, ".cmd_ready"}, cmd_ready, 1'b1);
  endtask

  // Issues a command in the current (idle) cycle with m_ready=1 and checks every beat.
  // cmd_valid stays high through the packet and any gap, where it must be ignored.
  task automatic send_pkt(input string tag, input int len, input logic [7:0] seed);
    logic [7:0] exp_d;
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    cmd_seed  = seed;
    m_ready   = 1'b1;
    for (int i = 0; i <= len; i++) begin
      step();
      exp_d = seed + i[7:0];
      check({tag, ".valid"}, m_valid, 1'b1);
      check({tag, ".data"},  m_data,  exp_d);
      check({tag, ".last"},  m_last,  (i == len));
      check({tag, ".cmd_ready_busy"}, {cmd_ready, busy}, 2'b01);
      if (i == 0) check({tag, ".no_stale_done"}, pkt_done, 1'b0);
    end
    step();
    check({tag, ".pkt_done"}, pkt_done, 1'b1);
`ifdef STREAM_TX_GAP_EN
    for (int g = 0; g < TB_GAP; g++) begin
      if (g > 0) step();
      check({tag, ".gap_valid"}, m_valid, 1'b0);
      check({tag, ".gap_rdy_busy"}, {cmd_ready, busy}, 2'b01);
    end
    step();
`endif
    check_idle({tag, ".end"});
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = 8'h00;
    cmd_seed  = 8'h00;
    m_ready   = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");
    check("reset.m_data",   m_data,   8'h00);
    check("reset.pkt_done", pkt_done, 1'b0);

    // Basic packet: 0x11..0x14, last on 0x14
    send_pkt("p1", 3, 8'h11);

    // Back-pressure: 0xAB held for three cycles
    cmd_valid = 1'b1; cmd_len = 8'd3; cmd_seed = 8'hAA; m_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("p2.b0", {m_valid, m_last, m_data}, {2'b10, 8'hAA});
    step();
    m_ready = 1'b0;
    check("p2.b1", {m_valid, m_last, m_data}, {2'b10, 8'hAB});
    step();
    check("p2.hold1", {m_valid, m_last, m_data}, {2'b10, 8'hAB});
    step();
    check("p2.hold2", {m_valid, m_last, m_data}, {2'b10, 8'hAB});
    m_ready = 1'b1;
    step();
    check("p2.b2", {m_valid, m_last, m_data}, {2'b10, 8'hAC});
    step();
    check("p2.b3", {m_valid, m_last, m_data}, {2'b11, 8'hAD});
    step();
    check("p2.done", {pkt_done, m_valid}, 2'b10);
`ifdef STREAM_TX_GAP_EN
    repeat (TB_GAP) step();
`endif
    check_idle("p2.end");

    // Single-beat packet, then data wrap, then max length
    send_pkt("p3", 0, 8'h7F);
    send_pkt("p4", 2, 8'hFE);
    send_pkt("pmax", 255, 8'h00);

    // Reset mid-packet, with a command presented on the reset edge
    cmd_valid = 1'b1; cmd_len = 8'd5; cmd_seed = 8'hEE; m_ready = 1'b0;
    step();
    check("p5.b0", {m_valid, m_last, m_data}, {2'b10, 8'hEE});
    step();
    check("p5.stall", {m_valid, m_data}, {1'b1, 8'hEE});
    reset = 1'b1;
    step();
    check_idle("p5.rst");
    check("p5.rst_data",  m_data,   8'h00);
    check("p5.rst_done",  pkt_done, 1'b0);
    reset = 1'b0;
    cmd_valid = 1'b0;
    step();
    check_idle("p5.dropped");
    send_pkt("p6", 1, 8'h01);

    step();
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
